clk_div_scheduler: RTL

//   Run-time controller for the programmable clock divider. Accepts divide-ratio/duty

---
 rtl/clk_div_scheduler_if.sv | 13 +
 rtl/clk_div_scheduler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/clk_div_scheduler_if.sv
// Configuration handshake bundle for the clock divider scheduler.
interface clk_div_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_div, cfg_high, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_div, cfg_high, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_scheduler.sv
// Run-time controller for a programmable clock divider: validates N/H requests and applies them
// only on period boundaries. Optional CLK_DIV_PERIOD_CNT_EN adds a saturating completed-period counter.
module clk_div_scheduler #(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_DIV  = 4,
  parameter int DEFAULT_HIGH = 2
) (
  input  logic               clockin_i,
  input  logic               reset_i,
  input  logic               enable_i,
  clk_div_scheduler_if.slave cfg_if,
  output logic               clockout_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               period_done_o,
  output logic [CNT_W-1:0]   active_div_o
`ifdef CLK_DIV_PERIOD_CNT_EN
  ,
  output logic [15:0]        period_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;

  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_HIGH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] sdiv_q, sdiv_d;
  logic [CNT_W-1:0] shigh_q, shigh_d;
  logic             clockout_q, clockout_d;
  logic             cfg_err_q, cfg_err_d;

  logic             accept;
  logic             cfg_ok;
  logic             take_cfg;
  logic             last_cycle;
  logic [CNT_W-1:0] count_inc;

  assign cfg_ok     = (cfg_if.cfg_div >= TWO) && (cfg_if.cfg_high != '0)
                      && (cfg_if.cfg_high < cfg_if.cfg_div);
  assign accept     = cfg_if.cfg_valid && cfg_if.cfg_ready;
  assign take_cfg   = accept && cfg_ok;
  assign last_cycle = (state_q != IDLE) && (count_q == div_q - ONE);
  assign count_inc  = count_q + ONE;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    clockout_d = clockout_q;
    div_d      = div_q;
    high_d     = high_q;
    sdiv_d     = sdiv_q;
    shigh_d    = shigh_q;
    cfg_err_d  = accept && !cfg_ok;

    case (state_q)
      IDLE: begin
        count_d    = '0;
        clockout_d = enable_i;
        if (take_cfg) begin
          div_d  = cfg_if.cfg_div;
          high_d = cfg_if.cfg_high;
        end
        if (enable_i) state_d = RUN;
      end
      default: begin
        if (last_cycle) begin
          // Wrap edge: the only place N/H may change while running, so no runt pulse.
          if (state_q == PEND) begin
            div_d  = sdiv_q;
            high_d = shigh_q;
          end else if (take_cfg) begin
            div_d  = cfg_if.cfg_div;
            high_d = cfg_if.cfg_high;
          end
          count_d    = '0;
          clockout_d = enable_i;
          state_d    = enable_i ? RUN : IDLE;
        end else begin
          count_d    = count_inc;
          clockout_d = (count_inc < high_q);
          if (take_cfg) begin
            sdiv_d  = cfg_if.cfg_div;
            shigh_d = cfg_if.cfg_high;
            state_d = PEND;
          end else if (state_q != PEND) begin
            state_d = enable_i ? RUN : STOP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clockin_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      clockout_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      div_q      <= DEF_DIV;
      high_q     <= DEF_HIGH;
      sdiv_q     <= '0;
      shigh_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      clockout_q <= clockout_d;
      cfg_err_q  <= cfg_err_d;
      div_q      <= div_d;
      high_q     <= high_d;
      sdiv_q     <= sdiv_d;
      shigh_q    <= shigh_d;
    end
  end

  assign cfg_if.cfg_ready = (state_q != PEND);
  assign cfg_if.cfg_err   = cfg_err_q;
  assign clockout_o       = clockout_q;
  assign count_o          = count_q;
  assign period_done_o    = last_cycle;
  assign active_div_o     = div_q;

`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0] pcnt_q, pcnt_d;
  logic        cfg_applied;

  assign cfg_applied = ((state_q == IDLE) && take_cfg)
                       || (last_cycle && ((state_q == PEND) || take_cfg));

  always_comb begin
    pcnt_d = pcnt_q;
    if (cfg_applied)
      pcnt_d = '0;
    else if (last_cycle && (pcnt_q != 16'hFFFF))
      pcnt_d = pcnt_q + 16'd1;
  end

  always_ff @(posedge clockin_i or posedge reset_i) begin
    if (reset_i) pcnt_q <= '0;
    else         pcnt_q <= pcnt_d;
  end

  assign period_cnt_o = pcnt_q;
`endif

endmodule
